// File: rtl/multi_wave_gen.sv
// -----------------------------------------------------------------------------
// multi_wave_gen
//   Frame-rate waveform generator. Each frame_sig pulse advances a frame
//   counter and produces one unsigned sample in the active mode (sawtooth,
//   square, optional triangle). A new period/mode request is captured on en.
//   Its step, floor(MAX/PERIOD_IN), comes from a restoring divider. The request
//   becomes active at the next cycle boundary after the division completes.
//
//   Optional feature: define MULTI_WAVE_TRIANGLE_EN to build the triangle
//   generator for mode 2. Without it, mode 2 behaves as sawtooth.
//
// Ports
//   BIT_CLK       in   single clock, rising edge
//   RST           in   synchronous active-high reset
//   frame_sig     in   one-cycle pulse per audio frame
//   en            in   load request for PERIOD_IN / MODE_IN
//   PERIOD_IN     in   requested period in frames (values < 2 are taken as 2)
//   MODE_IN       in   requested mode: 0 saw, 1 square, 2 triangle, 3 saw
//   WAVE_OUT      out  current unsigned sample
//   SAMPLE_VALID  out  one-cycle pulse after each WAVE_OUT update
//   PERIOD        out  active period
//   MODE          out  active mode
//   BUSY          out  step divider running
// -----------------------------------------------------------------------------
module multi_wave_gen #(
    parameter int SAMPLE_W     = 18,
    parameter int PERIOD_W     = 7,
    parameter int RESET_PERIOD = 48
) (
    input  logic                BIT_CLK,
    input  logic                RST,
    input  logic                frame_sig,
    input  logic                en,
    input  logic [PERIOD_W-1:0] PERIOD_IN,
    input  logic [1:0]          MODE_IN,
    output logic [SAMPLE_W-1:0] WAVE_OUT,
    output logic                SAMPLE_VALID,
    output logic [PERIOD_W-1:0] PERIOD,
    output logic [1:0]          MODE,
    output logic                BUSY
);

    typedef enum logic [1:0] {
        MODE_SAW    = 2'd0,
        MODE_SQUARE = 2'd1,
        MODE_TRI    = 2'd2,
        MODE_RSVD   = 2'd3
    } wave_mode_e;

    localparam logic [SAMPLE_W-1:0] MAX_VAL    = '1;
    localparam logic [SAMPLE_W-1:0] RESET_STEP = MAX_VAL / SAMPLE_W'(RESET_PERIOD);
    localparam int                  CNT_W      = $clog2(SAMPLE_W);
    localparam logic [CNT_W-1:0]    LAST_BIT   = CNT_W'(SAMPLE_W - 1);

    // Active state
    logic [PERIOD_W-1:0] fc;
    logic [SAMPLE_W-1:0] step;
    logic                pend_ready;

    // Pending request and divider datapath; quo holds the pending step once
    // the division has finished.
    logic [PERIOD_W-1:0] pend_period;
    logic [1:0]          pend_mode;
    logic [SAMPLE_W-1:0] quo;
    logic [PERIOD_W-1:0] rem;
    logic [CNT_W-1:0]    bit_cnt;

    logic [PERIOD_W-1:0] period_in_clamped;
    assign period_in_clamped = (PERIOD_IN < PERIOD_W'(2)) ? PERIOD_W'(2) : PERIOD_IN;

    // Restoring divider step. The dividend is MAX (all ones), so every step
    // shifts a 1 into the partial remainder. The remainder stays below the
    // divisor, so PERIOD_W bits hold it.
    logic [PERIOD_W:0]   trial;
    logic                quo_bit;
    logic [PERIOD_W-1:0] rem_next;

    // NOTE: every signal driven in an always_comb gets a default first, so no
    //       path leaves it unassigned and no latch is inferred.
    always_comb begin
        trial    = {rem, 1'b1};
        quo_bit  = (trial >= {1'b0, pend_period});
        rem_next = trial[PERIOD_W-1:0];
        if (quo_bit) begin
            rem_next = PERIOD_W'(trial - {1'b0, pend_period});
        end
    end

    // Next-sample computation. On the boundary frame that applies a pending
    // request, the new period, mode and step are used right away.
    logic                at_end;
    logic                apply;
    logic [PERIOD_W-1:0] fc_next;
    logic [PERIOD_W-1:0] act_period;
    wave_mode_e          act_mode;
    logic [SAMPLE_W-1:0] act_step;
    logic                first_half;
    logic [SAMPLE_W:0]   saw_sum;
    logic [SAMPLE_W-1:0] wave_next;
`ifdef MULTI_WAVE_TRIANGLE_EN
    logic [SAMPLE_W:0]   step2;
    logic [SAMPLE_W+1:0] tri_sum;
`endif

    always_comb begin
        at_end     = (fc == PERIOD - PERIOD_W'(1));
        apply      = frame_sig && at_end && pend_ready;
        fc_next    = at_end ? '0 : fc + PERIOD_W'(1);
        act_period = apply ? pend_period : PERIOD;
        act_mode   = wave_mode_e'(apply ? pend_mode : MODE);
        act_step   = apply ? quo : step;
        first_half = (fc_next < (act_period >> 1));
        saw_sum    = {1'b0, WAVE_OUT} + {1'b0, act_step};
`ifdef MULTI_WAVE_TRIANGLE_EN
        step2      = {act_step, 1'b0};
        tri_sum    = {2'b00, WAVE_OUT} + {1'b0, step2};
`endif
        // Sawtooth is the fallback for modes 0, 3 and (without the triangle
        // build) 2. A carry out of the add means the sum passed MAX.
        wave_next  = (fc_next == '0) ? '0
                   : (saw_sum[SAMPLE_W] ? MAX_VAL : saw_sum[SAMPLE_W-1:0]);
        case (act_mode)
            MODE_SQUARE: wave_next = first_half ? MAX_VAL : '0;
`ifdef MULTI_WAVE_TRIANGLE_EN
            MODE_TRI: begin
                if (fc_next == '0) begin
                    wave_next = '0;
                end else if (first_half) begin
                    wave_next = (tri_sum > {2'b00, MAX_VAL}) ? MAX_VAL
                                                             : tri_sum[SAMPLE_W-1:0];
                end else begin
                    wave_next = ({1'b0, WAVE_OUT} >= step2)
                              ? SAMPLE_W'({1'b0, WAVE_OUT} - step2) : '0;
                end
            end
`endif
            default: ;
        endcase
    end

    // Control and active state
    // NOTE: sequential state is written with non-blocking assignments only, so
    //       every register samples values from before the clock edge.
    always_ff @(posedge BIT_CLK) begin
        if (RST) begin
            WAVE_OUT     <= '0;
            SAMPLE_VALID <= 1'b0;
            fc           <= '0;
            PERIOD       <= PERIOD_W'(RESET_PERIOD);
            MODE         <= MODE_SAW;
            step         <= RESET_STEP;
            BUSY         <= 1'b0;
            pend_ready   <= 1'b0;
            bit_cnt      <= '0;
        end else begin
            SAMPLE_VALID <= frame_sig;
            if (frame_sig) begin
                fc       <= fc_next;
                WAVE_OUT <= wave_next;
                if (apply) begin
                    PERIOD <= pend_period;
                    MODE   <= pend_mode;
                    step   <= quo;
                end
            end
            // A new request restarts the divider and invalidates any result
            // that is already waiting.
            if (en) begin
                BUSY       <= 1'b1;
                bit_cnt    <= '0;
                pend_ready <= 1'b0;
            end else if (BUSY) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
                if (bit_cnt == LAST_BIT) begin
                    BUSY       <= 1'b0;
                    pend_ready <= 1'b1;
                end
            end else if (apply) begin
                pend_ready <= 1'b0;
            end
        end
    end

    // NOTE: the pending/divider datapath has no reset. Its contents are used
    //       only after en has loaded them and pend_ready has been set.
    always_ff @(posedge BIT_CLK) begin
        if (en) begin
            pend_period <= period_in_clamped;
            pend_mode   <= MODE_IN;
            rem         <= '0;
        end else if (BUSY) begin
            rem <= rem_next;
            quo <= {quo[SAMPLE_W-2:0], quo_bit};
        end
    end

endmodule
